// File: rtl/tempo_step_sequencer.sv
// Beat-driven step sequencer: walks a pattern RAM on each prescaler beat, issues
// note requests over valid/ready, and applies tempo changes on beat boundaries.
module tempo_step_sequencer #(
    parameter  int STEPS       = 16,
    parameter  int NOTE_W      = 8,
    parameter  int BPM_MIN     = 40,
    parameter  int BPM_MAX     = 240,
    parameter  int DEFAULT_BPM = 120,
    localparam int IDX_W       = $clog2(STEPS)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        bpm_req,
    input  logic              bpm_load,
    output logic [7:0]        bpm_out,
    input  logic              beat_clk,
    input  logic              pat_we,
    input  logic [IDX_W-1:0]  pat_addr,
    input  logic [NOTE_W:0]   pat_wdata,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [NOTE_W-1:0] note_code,
    output logic [IDX_W-1:0]  step_idx,
    output logic              running,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic              beat_meta, beat_sync, beat_prev;
    logic              beat_evt;
    logic              start_go;
    logic              step_go;
    logic [IDX_W-1:0]  next_idx;
    logic              sched_q;
    logic [NOTE_W:0]   rd_q;
    logic [NOTE_W:0]   mem [STEPS];
    logic [7:0]        pend_bpm;
    logic              pend_q;
    logic              bpm_copy;
    logic              sched_note;

    function automatic logic [7:0] clamp_bpm(input logic [7:0] v);
        if (v < 8'(BPM_MIN))
            return 8'(BPM_MIN);
        else if (v > 8'(BPM_MAX))
            return 8'(BPM_MAX);
        else
            return v;
    endfunction

    // Two flops resolve metastability; the third detects the rising edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            beat_meta <= 1'b0;
            beat_sync <= 1'b0;
            beat_prev <= 1'b0;
        end else begin
            beat_meta <= beat_clk;
            beat_sync <= beat_meta;
            beat_prev <= beat_sync;
        end
    end

    assign beat_evt = beat_sync & ~beat_prev;
    assign start_go = (state_q == IDLE) & start & ~stop;
    assign step_go  = beat_evt & (state_q != IDLE) & ~stop;
    assign next_idx = (state_q == ARM) ? '0 : step_idx + 1'b1;
    assign running  = (state_q != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)    state_d = ARM;
                ARM:     if (beat_evt) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: pattern storage and its read register carry no reset; contents survive nRST.
    always_ff @(posedge CLK) begin
        if (pat_we)
            mem[pat_addr] <= pat_wdata;
        if (step_go)
            rd_q <= mem[next_idx];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            step_idx <= '0;
            sched_q  <= 1'b0;
        end else begin
            sched_q <= step_go;
            if (stop)
                step_idx <= '0;
            else if (step_go)
                step_idx <= next_idx;
        end
    end

    // Pending tempo reaches the prescaler immediately when idle, else on the beat.
    assign bpm_copy = pend_q & ((state_q == IDLE) | step_go);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bpm_out  <= 8'(DEFAULT_BPM);
            pend_bpm <= 8'(DEFAULT_BPM);
            pend_q   <= 1'b0;
        end else begin
            if (bpm_copy)
                bpm_out <= pend_bpm;
            if (bpm_load) begin
                pend_bpm <= clamp_bpm(bpm_req);
                pend_q   <= 1'b1;
            end else if (bpm_copy) begin
                pend_q <= 1'b0;
            end
        end
    end

    assign sched_note = sched_q & rd_q[NOTE_W] & ~stop;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            note_valid <= 1'b0;
            note_code  <= '0;
            overrun    <= 1'b0;
        end else begin
            if (stop) begin
                note_valid <= 1'b0;
            end else if (sched_note) begin
                note_valid <= 1'b1;
                note_code  <= rd_q[NOTE_W-1:0];
            end else if (note_valid && note_ready) begin
                note_valid <= 1'b0;
            end

            if (start_go)
                overrun <= 1'b0;
            else if (sched_note && note_valid && !note_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tempo_step_sequencer.sv
// Directed bench for tempo_step_sequencer: tempo clamping, pattern walk,
// backpressure/overrun, stop handling and asynchronous reset.
module tb_tempo_step_sequencer;

    logic       CLK;
    logic       nRST;
    logic       start;
    logic       stop;
    logic [7:0] bpm_req;
    logic       bpm_load;
    logic [7:0] bpm_out;
    logic       beat_clk;
    logic       pat_we;
    logic [3:0] pat_addr;
    logic [8:0] pat_wdata;
    logic       note_valid;
    logic       note_ready;
    logic [7:0] note_code;
    logic [3:0] step_idx;
    logic       running;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;

    tempo_step_sequencer dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .start      (start),
        .stop       (stop),
        .bpm_req    (bpm_req),
        .bpm_load   (bpm_load),
        .bpm_out    (bpm_out),
        .beat_clk   (beat_clk),
        .pat_we     (pat_we),
        .pat_addr   (pat_addr),
        .pat_wdata  (pat_wdata),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_code  (note_code),
        .step_idx   (step_idx),
        .running    (running),
        .overrun    (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One beat_clk pulse; checks the step at the action edge and the note one edge later.
    task automatic beat(input int exp_idx, input bit pre_valid, input bit exp_valid,
                        input int exp_code, input string tag);
        beat_clk = 1'b1;
        tick();
        tick();
        tick();
        chk({tag, "_idx"}, 32'(step_idx), 32'(exp_idx));
        chk({tag, "_pre_valid"}, 32'(note_valid), 32'(pre_valid));
        tick();
        chk({tag, "_valid"}, 32'(note_valid), 32'(exp_valid));
        if (exp_valid)
            chk({tag, "_code"}, 32'(note_code), 32'(exp_code));
        beat_clk = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        nRST       = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        bpm_req    = 8'd0;
        bpm_load   = 1'b0;
        beat_clk   = 1'b0;
        pat_we     = 1'b0;
        pat_addr   = 4'd0;
        pat_wdata  = 9'd0;
        note_ready = 1'b0;

        // Reset and defaults
        tick();
        tick();
        nRST = 1'b1;
        tick();
        chk("rst_bpm", 32'(bpm_out), 32'd120);
        chk("rst_valid", 32'(note_valid), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_idx", 32'(step_idx), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_code", 32'(note_code), 32'd0);

        // Tempo clamp in IDLE
        bpm_req = 8'd20;  bpm_load = 1'b1; tick(); bpm_load = 1'b0;
        chk("idle_bpm_not_yet", 32'(bpm_out), 32'd120);
        tick();
        chk("clamp_low", 32'(bpm_out), 32'd40);
        bpm_req = 8'd100; bpm_load = 1'b1; tick(); bpm_load = 1'b0; tick();
        chk("clamp_mid", 32'(bpm_out), 32'd100);
        bpm_req = 8'd250; bpm_load = 1'b1; tick(); bpm_load = 1'b0; tick();
        chk("clamp_high", 32'(bpm_out), 32'd240);

        // Program notes 60..75, step 3 is a rest
        for (int i = 0; i < 16; i++) begin
            pat_we    = 1'b1;
            pat_addr  = 4'(i);
            pat_wdata = {(i != 3), 8'(60 + i)};
            tick();
        end
        pat_we = 1'b0;

        start = 1'b1; tick(); start = 1'b0;
        chk("start_running", 32'(running), 32'd1);
        chk("start_valid", 32'(note_valid), 32'd0);

        // Pattern walk with 17 beats, wrapping 15 -> 0
        note_ready = 1'b1;
        for (int b = 0; b < 17; b++) begin
            int idx;
            idx = b % 16;
            beat(idx, 1'b0, (idx != 3), 60 + idx, "walk");
        end

        // Tempo change in RUN waits for the beat
        bpm_req = 8'd90; bpm_load = 1'b1; tick(); bpm_load = 1'b0;
        tick();
        tick();
        chk("run_bpm_held", 32'(bpm_out), 32'd240);
        beat_clk = 1'b1;
        tick();
        tick();
        chk("run_bpm_before_beat", 32'(bpm_out), 32'd240);
        tick();
        chk("run_bpm_at_beat", 32'(bpm_out), 32'd90);
        chk("run_bpm_idx", 32'(step_idx), 32'd1);
        tick();
        chk("run_bpm_note_valid", 32'(note_valid), 32'd1);
        chk("run_bpm_note_code", 32'(note_code), 32'd61);
        beat_clk = 1'b0;
        repeat (3) tick();

        // Backpressure: rest beat keeps the note, next note replaces it
        note_ready = 1'b0;
        beat(2, 1'b0, 1'b1, 62, "bp_first");
        beat(3, 1'b1, 1'b1, 62, "bp_rest");
        chk("bp_no_overrun_on_rest", 32'(overrun), 32'd0);
        beat(4, 1'b1, 1'b1, 64, "bp_replace");
        chk("bp_overrun", 32'(overrun), 32'd1);
        chk("bp_still_valid", 32'(note_valid), 32'd1);

        // Stop with a note pending
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_valid", 32'(note_valid), 32'd0);
        chk("stop_idx", 32'(step_idx), 32'd0);
        chk("stop_running", 32'(running), 32'd0);
        chk("stop_overrun_sticky", 32'(overrun), 32'd1);
        chk("stop_bpm_hold", 32'(bpm_out), 32'd90);
        stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
        chk("stop_wins_running", 32'(running), 32'd0);
        tick();
        chk("stop_wins_idle", 32'(running), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_clears_overrun", 32'(overrun), 32'd0);
        chk("restart_running", 32'(running), 32'd1);

        // Asynchronous reset with a note pending
        beat(0, 1'b0, 1'b1, 60, "pre_reset");
        #2;
        nRST = 1'b0;
        #1;
        chk("areset_bpm", 32'(bpm_out), 32'd120);
        chk("areset_valid", 32'(note_valid), 32'd0);
        chk("areset_running", 32'(running), 32'd0);
        chk("areset_idx", 32'(step_idx), 32'd0);
        chk("areset_overrun", 32'(overrun), 32'd0);
        chk("areset_code", 32'(note_code), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();

        // Pattern survives reset
        start = 1'b1; tick(); start = 1'b0;
        note_ready = 1'b1;
        beat(0, 1'b0, 1'b1, 60, "post_reset");
        chk("post_reset_bpm", 32'(bpm_out), 32'd120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
